// File: rtl/tap_debounce_pkg.sv
// tap_debounce_pkg: FSM state encoding and hold-counter sizing for tap_debounce_edge
package tap_debounce_pkg;
    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_HOLD_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_HOLD_L = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int hold_w(input int h);
        return (clog2(h) < 1) ? 1 : clog2(h);
    endfunction
endpackage

// File: rtl/sat_cnt_tdb.sv
// sat_cnt_tdb: saturating up-counter with synchronous clear that overrides increment
module sat_cnt_tdb #(
    parameter int CNT_W = 16
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             INC_I,
    input  logic             CLR_I,
    output logic [CNT_W-1:0] CNT_O
);
    always_ff @(posedge CLK_I or negedge RSTN_I)
        if (!RSTN_I) CNT_O <= '0;
        else if (CLR_I) CNT_O <= '0;
        else if (INC_I && !(&CNT_O)) CNT_O <= CNT_O + 1'b1;
endmodule

// File: rtl/tap_debounce_edge.sv
// tap_debounce_edge: all-taps-agree debouncer with post-edge lockout, edge/glitch pulses and counters
module tap_debounce_edge
    import tap_debounce_pkg::*;
#(
    parameter int LEN     = 4,
    parameter int HOLDOFF = 8,
    parameter int CNT_W   = 16
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic [LEN-1:0]   TAPS_NEW2OLD_I,
    input  logic             CNT_CLR_I,
    output logic             LEVEL_O,
    output logic             RISE_O,
    output logic             FALL_O,
    output logic             GLITCH_O,
    output logic [CNT_W-1:0] EDGE_CNT_O,
    output logic [CNT_W-1:0] GLITCH_CNT_O
);
    localparam int HW = hold_w(HOLDOFF);
    localparam logic [HW-1:0] HOLD_INIT = HW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          rise_d, fall_d, glitch_d, level_d;
    logic          all_hi, all_lo, any_hi, any_lo;

    assign all_hi = &TAPS_NEW2OLD_I;
    assign all_lo = ~|TAPS_NEW2OLD_I;
    assign any_hi = |TAPS_NEW2OLD_I;
    assign any_lo = ~&TAPS_NEW2OLD_I;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pend_d   = pend_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (all_hi) begin
                    rise_d  = 1'b1;
                    pend_d  = 1'b0;
                    hold_d  = HOLD_INIT;
                    state_d = (HOLDOFF == 0) ? ST_HIGH : ST_HOLD_H;
                end else if (any_hi) begin
                    pend_d = 1'b1;
                end else if (pend_q && all_lo) begin
                    glitch_d = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            ST_HIGH: begin
                if (all_lo) begin
                    fall_d  = 1'b1;
                    pend_d  = 1'b0;
                    hold_d  = HOLD_INIT;
                    state_d = (HOLDOFF == 0) ? ST_LOW : ST_HOLD_L;
                end else if (any_lo) begin
                    pend_d = 1'b1;
                end else if (pend_q && all_hi) begin
                    glitch_d = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            // Lockout: taps are ignored entirely until the hold count expires
            default: begin
                pend_d  = 1'b0;
                hold_d  = (hold_q == '0) ? hold_q : hold_q - 1'b1;
                state_d = (hold_q != '0) ? state_q : (state_q == ST_HOLD_H) ? ST_HIGH : ST_LOW;
            end
        endcase
    end

    assign level_d = (state_d == ST_HOLD_H) || (state_d == ST_HIGH);

    always_ff @(posedge CLK_I or negedge RSTN_I)
        if (!RSTN_I) begin
            state_q  <= ST_LOW;
            hold_q   <= '0;
            pend_q   <= 1'b0;
            LEVEL_O  <= 1'b0;
            RISE_O   <= 1'b0;
            FALL_O   <= 1'b0;
            GLITCH_O <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            LEVEL_O  <= level_d;
            RISE_O   <= rise_d;
            FALL_O   <= fall_d;
            GLITCH_O <= glitch_d;
        end

    sat_cnt_tdb #(.CNT_W(CNT_W)) u_edge_cnt (
        .CLK_I (CLK_I),
        .RSTN_I(RSTN_I),
        .INC_I (rise_d | fall_d),
        .CLR_I (CNT_CLR_I),
        .CNT_O (EDGE_CNT_O)
    );

    sat_cnt_tdb #(.CNT_W(CNT_W)) u_glitch_cnt (
        .CLK_I (CLK_I),
        .RSTN_I(RSTN_I),
        .INC_I (glitch_d),
        .CLR_I (CNT_CLR_I),
        .CNT_O (GLITCH_CNT_O)
    );
endmodule
